big_shiftmix_stage: RTL and testbench
=====================================

BIG_SHIFTMIX_STAGE -- requirements
Module: big_shiftmix_stage

Interface
REQ-001 Parameter: ROUNDS, 8, ECHO rounds per compression (8 for ECHO-256, 10 for ECHO-512); legal 1..15.
REQ-002 Port: clk  input  1  sole clock, all state on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: in_valid  input  1  in_word holds a valid post-BIG.SUBWORDS word.
REQ-005 Port: in_ready  output  1  block accepts a word this cycle.
REQ-006 Port: in_word  input  128  state word; byte 0 = bits [127:120].
REQ-007 Port: out_valid  output  1  out_word valid.
REQ-008 Port: out_ready  input  1  consumer accepts out_word.
REQ-009 Port: out_word  output  128  result word after BIG.SHIFTROWS + BIG.MIXCOLUMNS.
REQ-010 Port: out_last_round  output  1  current output block is the final round (see REQ-024).

Function
REQ-011 The block SHALL process one 2048-bit ECHO state as 16 words; word index k = 4*j + i (row i, column j, column-major), streamed in ascending k on input and output.
REQ-012 The FSM SHALL have states COLLECT, MIX, DRAIN; reset state COLLECT.
REQ-013 In COLLECT, in_ready SHALL be 1; each in_valid&in_ready handshake stores one word and increments a 4-bit write index.
REQ-014 The word with index k = 4*j + i SHALL be stored at the ShiftRows destination row i, column (j - i) mod 4.
REQ-015 On the 16th COLLECT handshake, the FSM SHALL go to MIX next cycle; in_ready SHALL be 0 in MIX and DRAIN, and in_valid SHALL be ignored there.
REQ-016 MIX SHALL last exactly 4 cycles, one column per cycle (column 0 first). Each cycle, for each byte position b = 0..15, the four bytes of rows 0..3 at position b SHALL be replaced in place by AES MixColumns with row 0 as the most significant byte.
REQ-017 After the 4th MIX cycle, the FSM SHALL enter DRAIN with out_valid = 1 and read index 0.
REQ-018 Latency: word 0 SHALL appear at out_word exactly 5 cycles after the clock edge that accepts input word 15.
REQ-019 In DRAIN, out_word SHALL be the stored word at the read index, registered with no combinational path from in_word.
REQ-020 When out_valid is 1 and out_ready is 0, out_word and out_valid SHALL hold stable. The read index SHALL advance only on out_valid&out_ready.
REQ-021 On the handshake for word 15, out_valid SHALL drop and the FSM SHALL return to COLLECT next cycle. Block n+1 input SHALL NOT overlap block n output.
REQ-022 Words arriving with gaps (in_valid low) SHALL NOT change stored data or indices.

Reset
REQ-023 While rst = 1 at a clock edge:
- FSM goes to COLLECT; write and read indices go to 0.
- out_valid goes to 0; out_last_round goes to 0; the round counter is cleared.
- in_ready SHALL be 0 during the rst-high cycle and 1 on the first cycle after.
- A partially collected or draining block SHALL be discarded.
- Buffer contents SHALL NOT be reset and SHALL be unobservable until rewritten.

Configuration
REQ-024 Macro ECHO_ROUND_CNT_EN, when defined:
- A 4-bit round counter SHALL increment on each completed DRAIN (word 15 handshake) and wrap from ROUNDS-1 to 0.
- out_last_round SHALL be 1 throughout DRAIN when the counter equals ROUNDS-1.
REQ-025 Without ECHO_ROUND_CNT_EN, no counter SHALL exist and out_last_round SHALL be constant 0. All other behaviour SHALL be identical.

Verification
REQ-026 Reset: hold rst 3 cycles with in_valid = 1 -> in_ready = 0 and out_valid = 0; the cycle after release, in_ready = 1.
REQ-027 MixColumns vector: words 0, 5, 10, 15 with every byte = 0xdb, 0x13, 0x53, 0x45 respectively, others 0 -> out words 0..3 have every byte 0x8e, 0x4d, 0xa1, 0xbc; words 4..15 = 0.
REQ-028 ShiftRows: only word 1 nonzero with every byte 0x01 -> out words 12, 13, 14, 15 have every byte 0x03, 0x02, 0x01, 0x01; all others 0.
REQ-029 Back-pressure: out_ready held 0 for 7 cycles at word 6 -> word 6 stable and out_valid = 1 throughout; in_ready = 0 until 1 cycle after the word 15 handshake; exactly 16 output handshakes.
REQ-030 Reset mid-operation: assert rst after 9 input words, then send a full all-zero block -> output is 16 zero words, with no data from the aborted block.
REQ-031 ECHO_ROUND_CNT_EN, ROUNDS = 8: stream 9 blocks -> out_last_round = 1 only during block 8's drain and 0 for block 9 (wrap); without the macro, out_last_round = 0 for all 9.

Source files
------------

// File: rtl/big_shiftmix_stage_if.sv
// Stream interface for big_shiftmix_stage: 128-bit input words in, mixed words out.
// The stage itself binds the slave modport; the producer/consumer binds master.
interface big_shiftmix_stage_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_word;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_word;
    logic         out_last_round;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, out_last_round
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, out_last_round
    );
endinterface

// File: rtl/big_shiftmix_stage.sv
// ECHO BIG.SHIFTROWS + BIG.MIXCOLUMNS over a 16-word state buffer (COLLECT -> MIX -> DRAIN).
// Optional round counter driving out_last_round is enabled by defining ECHO_ROUND_CNT_EN.
module big_shiftmix_stage #(
    parameter int ROUNDS = 8
) (
    input logic                    clk,
    input logic                    rst,
    big_shiftmix_stage_if.slave    bus
);

    if (ROUNDS < 1 || ROUNDS > 15) begin : g_rounds_check
        $error("big_shiftmix_stage: ROUNDS must be in 1..15");
    end

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        MIX     = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [3:0]   wr_idx;
    logic [3:0]   rd_idx;
    logic [3:0]   rd_next;
    logic [1:0]   wr_col;
    logic [1:0]   mix_col;
    logic         in_fire;
    logic         out_fire;
    logic         out_valid_q;
    logic [127:0] out_word_q;

    // mem[row][column]; each entry is one 128-bit ECHO word (16 AES bytes).
    logic [127:0] mem [4][4];
    logic [127:0] mix_out [4];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // AES MixColumns on one 4-byte column, row 0 in the most significant byte.
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    assign bus.in_ready  = (state_q == COLLECT) && !rst;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = out_valid_q && bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign rd_next       = rd_idx + 4'd1;

    // ShiftRows is folded into the write address: word (row i, col j) lands in column j - i.
    assign wr_col = wr_idx[3:2] - wr_idx[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (in_fire && wr_idx == 4'd15) state_d = MIX;
            MIX:     if (mix_col == 2'd3)            state_d = DRAIN;
            DRAIN:   if (out_fire && rd_idx == 4'd15) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // One buffer column per MIX cycle; each byte lane of the four row words is one AES column.
    always_comb begin : mix_comb
        logic [31:0] col_in;
        logic [31:0] col_res;
        col_in  = '0;
        col_res = '0;
        for (int r = 0; r < 4; r++) begin
            mix_out[r] = '0;
        end
        for (int b = 0; b < 16; b++) begin
            col_in = {mem[0][mix_col][8*(15-b) +: 8],
                      mem[1][mix_col][8*(15-b) +: 8],
                      mem[2][mix_col][8*(15-b) +: 8],
                      mem[3][mix_col][8*(15-b) +: 8]};
            col_res = mix_column(col_in);
            mix_out[0][8*(15-b) +: 8] = col_res[31:24];
            mix_out[1][8*(15-b) +: 8] = col_res[23:16];
            mix_out[2][8*(15-b) +: 8] = col_res[15:8];
            mix_out[3][8*(15-b) +: 8] = col_res[7:0];
        end
    end

    // NOTE: the state buffer is deliberately not reset; it is fully rewritten before any read.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_idx[1:0]][wr_col] <= bus.in_word;
        end else if (state_q == MIX) begin
            for (int r = 0; r < 4; r++) begin
                mem[r][mix_col] <= mix_out[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx      <= 4'd0;
            rd_idx      <= 4'd0;
            mix_col     <= 2'd0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else begin
            if (in_fire) begin
                wr_idx <= wr_idx + 4'd1;
            end
            if (state_q == MIX) begin
                mix_col <= mix_col + 2'd1;
            end
            // Column 0 is final since the first MIX cycle, so word 0 can be staged on the last one.
            if (state_q == MIX && mix_col == 2'd3) begin
                out_valid_q <= 1'b1;
                out_word_q  <= mem[0][0];
                rd_idx      <= 4'd0;
            end else if (out_fire) begin
                rd_idx <= rd_next;
                if (rd_idx == 4'd15) begin
                    out_valid_q <= 1'b0;
                end else begin
                    out_word_q <= mem[rd_next[1:0]][rd_next[3:2]];
                end
            end
        end
    end

`ifdef ECHO_ROUND_CNT_EN
    logic [3:0] round_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            round_q <= 4'd0;
        end else if (out_fire && rd_idx == 4'd15) begin
            round_q <= (round_q == 4'(ROUNDS - 1)) ? 4'd0 : round_q + 4'd1;
        end
    end

    assign bus.out_last_round = out_valid_q && (round_q == 4'(ROUNDS - 1));
`else
    assign bus.out_last_round = 1'b0;
`endif

endmodule

// File: tb/tb_big_shiftmix_stage.sv
// Self-checking bench for big_shiftmix_stage: directed vectors plus random blocks against
// a byte-level ShiftRows/MixColumns reference model. Honours ECHO_ROUND_CNT_EN if defined.
module tb_big_shiftmix_stage;

    localparam int ROUNDS = 8;

    typedef logic [127:0] word_t;
    typedef word_t blk_t [16];

    localparam int MC [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   blocks_done = 0;
    blk_t stim;
    blk_t expect_blk;

    always #5 clk = ~clk;

    big_shiftmix_stage_if bus ();

    big_shiftmix_stage #(.ROUNDS(ROUNDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input word_t observed, input word_t expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic word_t rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic word_t splat(input logic [7:0] b);
        return {16{b}};
    endfunction

    // GF(2^8) multiply, shift-and-add with the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Reference: place words on a 4x4 grid, rotate row i left by i, then matrix-multiply each byte lane.
    function automatic blk_t model(input blk_t w);
        word_t      grid  [4][4];
        word_t      mixed [4][4];
        blk_t       o;
        logic [7:0] col [4];
        logic [7:0] acc;
        for (int k = 0; k < 16; k++) begin
            grid[k % 4][((k / 4) - (k % 4) + 4) % 4] = w[k];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) mixed[r][c] = '0;
            for (int b = 0; b < 16; b++) begin
                for (int r = 0; r < 4; r++) col[r] = grid[r][c][8*(15-b) +: 8];
                for (int r = 0; r < 4; r++) begin
                    acc = 8'h00;
                    for (int x = 0; x < 4; x++) acc = acc ^ gmul(8'(MC[r][x]), col[x]);
                    mixed[r][c][8*(15-b) +: 8] = acc;
                end
            end
        end
        for (int k = 0; k < 16; k++) o[k] = mixed[k % 4][k / 4];
        return o;
    endfunction

    task automatic send_words(input blk_t w, input int n, input int gap_pct);
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_word  = rand_word();
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_word  = w[k];
            check("collect_in_ready", bus.in_ready, 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_last_round", bus.out_last_round, 0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", bus.in_ready, 1);
        blocks_done = 0;
    endtask

    task automatic run_block(input blk_t w, input blk_t exp_w, input int gap_pct,
                             input int ready_pct, input int stall_at);
        logic exp_last;
        int   stall;
        int   guard;
`ifdef ECHO_ROUND_CNT_EN
        exp_last = ((blocks_done % ROUNDS) == ROUNDS - 1);
`else
        exp_last = 1'b0;
`endif
        send_words(w, 16, gap_pct);
        // Garbage offered during MIX must be ignored; word 0 shows in the 5th cycle after word 15.
        bus.in_valid = 1'b1;
        bus.in_word  = rand_word();
        for (int n = 1; n <= 5; n++) begin
            check("latency_in_ready", bus.in_ready, 0);
            check("latency_out_valid", bus.out_valid, (n == 5));
            if (n < 5) @(negedge clk);
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            stall = (k == stall_at) ? 7 : 0;
            guard = 0;
            forever begin
                check("drain_out_valid", bus.out_valid, 1);
                check($sformatf("drain_word%0d", k), bus.out_word, exp_w[k]);
                check("drain_last_round", bus.out_last_round, exp_last);
                check("drain_in_ready", bus.in_ready, 0);
                if (stall > 0) begin
                    bus.out_ready = 1'b0;
                    stall--;
                end else begin
                    bus.out_ready = ($urandom_range(99) < ready_pct);
                end
                @(negedge clk);
                if (bus.out_ready) break;
                guard++;
                if (guard > 64) begin
                    checks++;
                    failures++;
                    $error("FAIL drain_timeout word=%0d waited=%0d cycles", k, guard);
                    break;
                end
            end
        end
        bus.out_ready = 1'b0;
        check("done_out_valid", bus.out_valid, 0);
        check("done_in_ready", bus.in_ready, 1);
        blocks_done++;
    endtask

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_word   = rand_word();
        bus.out_ready = 1'b0;
        rst           = 1'b1;

        // Reset held three cycles with in_valid asserted.
        repeat (3) begin
            @(negedge clk);
            check("hold_reset_in_ready", bus.in_ready, 0);
            check("hold_reset_out_valid", bus.out_valid, 0);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("release_in_ready", bus.in_ready, 1);

        // MixColumns known-answer vector.
        for (int k = 0; k < 16; k++) begin stim[k] = '0; expect_blk[k] = '0; end
        stim[0]  = splat(8'hdb);
        stim[5]  = splat(8'h13);
        stim[10] = splat(8'h53);
        stim[15] = splat(8'h45);
        expect_blk[0] = splat(8'h8e);
        expect_blk[1] = splat(8'h4d);
        expect_blk[2] = splat(8'ha1);
        expect_blk[3] = splat(8'hbc);
        run_block(stim, expect_blk, 0, 100, -1);

        // ShiftRows placement: row 1, column 0 moves to column 3.
        for (int k = 0; k < 16; k++) begin stim[k] = '0; expect_blk[k] = '0; end
        stim[1] = splat(8'h01);
        expect_blk[12] = splat(8'h03);
        expect_blk[13] = splat(8'h02);
        expect_blk[14] = splat(8'h01);
        expect_blk[15] = splat(8'h01);
        run_block(stim, expect_blk, 25, 100, -1);

        // Back-pressure: 7-cycle stall at word 6.
        for (int k = 0; k < 16; k++) stim[k] = rand_word();
        expect_blk = model(stim);
        run_block(stim, expect_blk, 0, 100, 6);

        // Random blocks with input gaps and random output back-pressure.
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 16; k++) stim[k] = rand_word();
            expect_blk = model(stim);
            run_block(stim, expect_blk, 30, 50, -1);
        end

        // Reset after 9 input words, then an all-zero block must come out all-zero.
        for (int k = 0; k < 16; k++) stim[k] = rand_word() | splat(8'h80);
        send_words(stim, 9, 20);
        do_reset();
        for (int k = 0; k < 16; k++) begin stim[k] = '0; expect_blk[k] = '0; end
        run_block(stim, expect_blk, 0, 70, -1);

        // Nine consecutive blocks from reset: round flag only on the 8th when the counter exists.
        do_reset();
        for (int n = 0; n < 9; n++) begin
            for (int k = 0; k < 16; k++) stim[k] = rand_word();
            expect_blk = model(stim);
            run_block(stim, expect_blk, 10, 80, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
